// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - pipeline-side memory access bus between EXE/MEM and sram_controller
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  rd_en, wr_en, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store sequencer over a 16-bit asynchronous SRAM, stalling via ready
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = 18
) (
  input  logic                clk,
  input  logic                rst,
  sram_controller_if.slave    bus,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [15:0]         SRAM_DQ,
  output logic                SRAM_WE_N
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [3:0]        counter;
  logic [ADDR_W-2:0] word_idx;
  logic [ADDR_W-2:0] word_next;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              req;
  logic              in_phase;
  logic              phase_last;
  logic              hi_phase;
  logic              dq_oe;
  logic [15:0]       dq_out;
  logic              ready_c;

  assign req        = bus.rd_en | bus.wr_en;
  // Out-of-window addresses simply wrap into the SRAM word space.
  assign word_next  = (ADDR_W-1)'((bus.address - 32'(BASE_ADDR)) >> 2);
  assign in_phase   = state inside {RD_LO, RD_HI, WR_LO, WR_HI};
  assign phase_last = in_phase && (counter == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= 4'd0;
    end else begin
      state   <= state_next;
      counter <= (in_phase && !phase_last) ? counter + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.wr_en)      state_next = WR_LO;
               else if (bus.rd_en) state_next = RD_LO;
      RD_LO:   if (phase_last)     state_next = RD_HI;
      RD_HI:   if (phase_last)     state_next = DONE;
      WR_LO:   if (phase_last)     state_next = WR_HI;
      WR_HI:   if (phase_last)     state_next = DONE;
      DONE:                        state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx <= '0;
      wdata    <= 32'd0;
      rdata    <= 32'd0;
    end else begin
      if (state == IDLE && req) begin
        word_idx <= word_next;
        wdata    <= bus.writeData;
      end
      // Sample at the end of each read phase so the SRAM has the full wait time to settle.
      if (state == RD_LO && phase_last) rdata[15:0]  <= SRAM_DQ;
      if (state == RD_HI && phase_last) rdata[31:16] <= SRAM_DQ;
    end
  end

  always_comb begin
    ready_c   = 1'b0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = 16'h0000;
    hi_phase  = 1'b0;
    case (state)
      IDLE:  ready_c = !req;
      WR_LO: begin
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = wdata[15:0];
      end
      WR_HI: begin
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = wdata[31:16];
        hi_phase  = 1'b1;
      end
      RD_HI: hi_phase = 1'b1;
      DONE:  ready_c  = 1'b1;
      default: ;
    endcase
  end

  assign bus.ready    = ready_c;
  assign bus.readData = rdata;
  assign SRAM_ADDR    = {word_idx, hi_phase};
  assign SRAM_DQ      = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the data-memory access whose address and store data come from the execute stage (ALU result as address, forwarded Rm value as store data).
- Maps each 32-bit load/store onto an external 16-bit asynchronous SRAM as two half-word phases, each with a programmable wait count.
- Holds the ready line low for the whole access so the pipeline freezes until the access completes.
- Sits in the memory stage, between the EXE/MEM pipeline register and the off-chip SRAM pins.

Parameters:
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- WAIT_CYCLES, 3, cycles each half-word phase is held; legal range 1..15.
- ADDR_W, 18, SRAM address width; the low bit selects the half-word.

Ports:
- clk  input  1  rising-edge system clock.
- rst  input  1  asynchronous reset, active-high.
- rd_en  input  1  load request, qualified by ready.
- wr_en  input  1  store request, qualified by ready.
- address  input  32  byte address from the execute stage ALU result.
- writeData  input  32  store data (forwarded Rm value).
- readData  output  32  load result; valid when ready=1 after a load.
- ready  output  1  0 = access in progress, freeze the pipeline.
- SRAM_ADDR  output  ADDR_W  SRAM half-word address.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_WE_N  output  1  SRAM write strobe, active-low.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state=IDLE, counter=0, readData=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ high-Z.
  - Any access in flight is abandoned; no partial write is completed.
- States are IDLE, RD_LO, RD_HI, WR_LO, WR_HI and DONE. The 4-bit counter is used only in the four phase states.
- ready is combinational:
  - ready=1 in IDLE when rd_en=0 and wr_en=0.
  - ready=1 in DONE.
  - ready=0 otherwise, including in IDLE during the cycle a request is present.
- IDLE with a request, at the clock edge:
  - Capture word index w = (address - BASE_ADDR) >> 2, using the low ADDR_W-1 bits (modulo; out-of-range addresses wrap with no error).
  - Capture writeData.
  - Clear counter and enter WR_LO if wr_en=1, else RD_LO.
  - wr_en has priority when both wr_en and rd_en are asserted; the result is a store only.
- Phase states:
  - SRAM_ADDR = {w, 0} in the LO states and {w, 1} in the HI states.
  - counter increments every cycle. When counter == WAIT_CYCLES-1, advance LO->HI or HI->DONE and clear counter.
  - Each phase therefore lasts exactly WAIT_CYCLES cycles.
- Write phases:
  - SRAM_WE_N=0.
  - SRAM_DQ drives writeData[15:0] in WR_LO and writeData[31:16] in WR_HI.
- Read phases:
  - SRAM_WE_N=1 and SRAM_DQ is high-Z.
  - On the final cycle of RD_LO, sample SRAM_DQ into readData[15:0]; on the final cycle of RD_HI, into readData[31:16].
- Outside the phase states: SRAM_WE_N=1 and SRAM_DQ is high-Z.
- DONE:
  - Lasts exactly one cycle with ready=1, then returns to IDLE unconditionally.
  - Requests seen during DONE are not captured; they belong to the instruction already advancing.
- readData holds its value until the next load overwrites it; stores leave it unchanged.
- Latency: with the request captured at edge t, DONE is entered at edge t + 2*WAIT_CYCLES; ready rises in the same cycle. With the default, 7 stall cycles precede the ready cycle.
- Back-to-back requests: IDLE re-captures at the edge after DONE, with no idle gap required.
- Requests deasserted mid-access are ignored; the access runs to DONE on the captured values.

Test Plan:
- Reset, then idle -> ready=1, SRAM_WE_N=1, SRAM_DQ=Z, readData=0.
- Store: wr_en=1, address=1028, writeData=0xDEADBEEF (WAIT=3) ->
  - SRAM_ADDR=2 with DQ=0xBEEF and WE_N=0 for 3 cycles.
  - Then SRAM_ADDR=3 with DQ=0xDEAD for 3 cycles.
  - Then ready=1 for one cycle; total ready=0 for 7 cycles.
- Load of the same address with an SRAM model -> readData=0xDEADBEEF on the DONE cycle, SRAM_DQ never driven by the controller.
- rd_en=1 and wr_en=1 together at address=1024 -> only a write occurs at SRAM_ADDR 0/1 and readData is unchanged.
- Back-to-back store then load at address=1032 -> the second capture happens on the edge after DONE, and the load returns the stored word.
- rst pulsed during WR_HI -> WE_N=1 and DQ=Z immediately, state=IDLE, ready=1. A later load from the HI half-word returns the old contents.
